program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
Parameters:
REQ-001 The block SHALL have parameter BITNESS, default 64, which sets the processor word width and the pc width.
REQ-002 The block SHALL have parameter ADDR_W, default 10, which sets the instruction memory depth DEPTH = 2**ADDR_W 16-bit words.

Ports:
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port load_start, input, 1 bit: single-cycle pulse that begins a load session.
REQ-006 The block SHALL have port byte_valid, input, 1 bit: the upstream byte is valid.
REQ-007 The block SHALL have port byte_data, input, 8 bits: the upstream byte.
REQ-008 The block SHALL have port byte_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 The block SHALL have port pc, input, BITNESS bits: the processor program counter.
REQ-010 The block SHALL have port instruction, output, 16 bits: the instruction fed to the processor.
REQ-011 The block SHALL have port cpu_rst, output, 1 bit: reset to the processor; high holds it.
REQ-012 The block SHALL have port load_done, output, 1 bit: one-cycle pulse on successful load completion.
REQ-013 The block SHALL have port load_error, output, 1 bit: sticky length-overflow flag.
REQ-014 The block SHALL have port words_loaded, output, ADDR_W+1 bits: count of words written in the current session.

Function
REQ-015 The block SHALL implement FSM states IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI and ERR.
REQ-016 A byte handshake SHALL occur only on a rising edge where byte_valid and byte_ready are both 1.
REQ-017 byte_ready SHALL be 1 in LEN_LO, LEN_HI, DATA_LO and DATA_HI, and 0 in IDLE and ERR.
REQ-018 Stream format SHALL be: 16-bit word count N, little-endian (low byte first), then N instructions of 2 bytes each, each little-endian.
REQ-019 load_start in any state SHALL, on that edge, move the FSM to LEN_LO, clear words_loaded, clear load_error and clear the loaded_ok flag; an in-flight session is abandoned.
REQ-020 load_start SHALL take priority over a byte handshake occurring on the same edge; that byte is consumed and discarded.
REQ-021 On a handshake in LEN_LO the block SHALL latch the low count byte and go to LEN_HI.
REQ-022 On a handshake in LEN_HI with N=0 the block SHALL go to IDLE, set loaded_ok and pulse load_done.
REQ-023 On a handshake in LEN_HI with N>DEPTH the block SHALL go to ERR and set load_error to 1.
REQ-024 On a handshake in LEN_HI with 1<=N<=DEPTH the block SHALL go to DATA_LO.
REQ-025 On a handshake in DATA_LO the block SHALL latch the low instruction byte and go to DATA_HI.
REQ-026 On a handshake in DATA_HI the block SHALL write mem[words_loaded] <= {byte_data, low byte} and increment words_loaded; it returns to DATA_LO if the new count < N, otherwise it goes to IDLE, sets loaded_ok and pulses load_done.
REQ-027 ERR SHALL be left only via load_start or rst.
REQ-028 load_done SHALL be high exactly in the first cycle the FSM is in IDLE after successful completion.
REQ-029 cpu_rst SHALL equal rst OR (state != IDLE) OR (NOT loaded_ok), so it deasserts in the same cycle load_done is high.
REQ-030 instruction SHALL be a combinational read of mem[pc[ADDR_W-1:0]] when pc < DEPTH, and 16'h0000 when pc >= DEPTH.
REQ-031 A memory write SHALL become visible on instruction starting in the cycle after the write edge.
REQ-032 Memory contents SHALL NOT be reset or cleared; they persist across rst and across sessions, and words beyond N are left unchanged.
REQ-033 The block SHALL perform no writes outside DATA_HI handshakes.

Reset
REQ-034 On rst, asynchronously: state=IDLE, loaded_ok=0, load_error=0, load_done=0, words_loaded=0, latched bytes=0, byte_ready=0 and cpu_rst=1.
REQ-035 Reset asserted mid-session SHALL abandon the session; words already written SHALL remain in memory, and cpu_rst SHALL stay 1 until a later session completes.

Verification
REQ-036 Reset, then load_start, then bytes 02 00 34 12 CD AB -> mem[0]=16'h1234, mem[1]=16'hABCD; load_done pulses one cycle after the last byte; cpu_rst falls in that cycle; words_loaded=2; pc=1 gives instruction=16'hABCD.
REQ-037 load_start, then bytes 00 00 -> IDLE, load_done pulses, cpu_rst=0, memory unchanged.
REQ-038 ADDR_W=10, load_start, then bytes 01 04 (N=1025) -> state ERR, load_error=1, byte_ready=0, cpu_rst=1; a later load_start clears load_error.
REQ-039 byte_valid toggled randomly with gaps during a 3-word load -> identical memory contents and no extra writes; load_start issued after the 2nd word restarts the session, words_loaded=0, and old words persist.
REQ-040 Assert rst after 1 of 4 words is written -> cpu_rst=1, mem[0] retains its value; pc >= DEPTH at any time gives instruction=16'h0000.

Source files
------------

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program loader feeding a processor instruction memory
module program_loader #(
   parameter int BITNESS = 64,
   parameter int ADDR_W  = 10
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load_start,
   input  logic               byte_valid,
   input  logic [7:0]         byte_data,
   output logic               byte_ready,
   input  logic [BITNESS-1:0] pc,
   output logic [15:0]        instruction,
   output logic               cpu_rst,
   output logic               load_done,
   output logic               load_error,
   output logic [ADDR_W:0]    words_loaded
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [16:0] DEPTH_W = 17'(DEPTH);

   typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, ERR} state_t;

   state_t          state, state_n;
   logic [7:0]      len_lo, len_lo_n;
   logic [7:0]      data_lo, data_lo_n;
   logic [15:0]     n_words, n_words_n;
   logic [ADDR_W:0] words_n;
   logic            loaded_ok, ok_n;
   logic            err_n, done_n;
   logic            wr_en;
   logic            handshake;
   logic            in_range;
   logic [15:0]     len_full;
   logic [16:0]     next_count;
   logic [15:0]     mem [DEPTH];

   assign byte_ready = (state == LEN_LO) || (state == LEN_HI) ||
                       (state == DATA_LO) || (state == DATA_HI);
   assign handshake  = byte_valid && byte_ready;
   assign len_full   = {byte_data, len_lo};
   assign next_count = 17'(words_loaded) + 17'd1;
   assign cpu_rst    = rst || (state != IDLE) || !loaded_ok;
   assign in_range   = ((pc >> ADDR_W) == '0);
   assign instruction = in_range ? mem[pc[ADDR_W-1:0]] : 16'h0000;

   // State and session registers; memory is deliberately outside the reset domain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         len_lo       <= '0;
         data_lo      <= '0;
         n_words      <= '0;
         words_loaded <= '0;
         loaded_ok    <= 1'b0;
         load_error   <= 1'b0;
         load_done    <= 1'b0;
      end else begin
         state        <= state_n;
         len_lo       <= len_lo_n;
         data_lo      <= data_lo_n;
         n_words      <= n_words_n;
         words_loaded <= words_n;
         loaded_ok    <= ok_n;
         load_error   <= err_n;
         load_done    <= done_n;
      end
   end

   // Next-state logic; load_start wins over any byte arriving on the same edge
   always_comb begin
      state_n   = state;
      len_lo_n  = len_lo;
      data_lo_n = data_lo;
      n_words_n = n_words;
      words_n   = words_loaded;
      ok_n      = loaded_ok;
      err_n     = load_error;
      done_n    = 1'b0;
      wr_en     = 1'b0;
      if (load_start) begin
         state_n = LEN_LO;
         words_n = '0;
         ok_n    = 1'b0;
         err_n   = 1'b0;
      end else if (handshake) begin
         case (state)
            LEN_LO: begin
               len_lo_n = byte_data;
               state_n  = LEN_HI;
            end
            LEN_HI: begin
               n_words_n = len_full;
               if (len_full == 16'd0) begin
                  state_n = IDLE;
                  ok_n    = 1'b1;
                  done_n  = 1'b1;
               end else if ({1'b0, len_full} > DEPTH_W) begin
                  state_n = ERR;
                  err_n   = 1'b1;
               end else begin
                  state_n = DATA_LO;
               end
            end
            DATA_LO: begin
               data_lo_n = byte_data;
               state_n   = DATA_HI;
            end
            DATA_HI: begin
               wr_en   = 1'b1;
               words_n = next_count[ADDR_W:0];
               if (next_count < {1'b0, n_words}) begin
                  state_n = DATA_LO;
               end else begin
                  state_n = IDLE;
                  ok_n    = 1'b1;
                  done_n  = 1'b1;
               end
            end
            default: state_n = state;
         endcase
      end
   end

   // Instruction memory write port: one word per completed DATA_HI handshake
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[words_loaded[ADDR_W-1:0]] <= {byte_data, data_lo};
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

   localparam int BITNESS = 64;
   localparam int ADDR_W  = 10;

   logic               clk = 1'b0;
   logic               rst;
   logic               load_start;
   logic               byte_valid;
   logic [7:0]         byte_data;
   logic               byte_ready;
   logic [BITNESS-1:0] pc;
   logic [15:0]        instruction;
   logic               cpu_rst;
   logic               load_done;
   logic               load_error;
   logic [ADDR_W:0]    words_loaded;

   int n_cmp = 0;
   int n_err = 0;

   program_loader #(.BITNESS(BITNESS), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .load_start(load_start), .byte_valid(byte_valid),
      .byte_data(byte_data), .byte_ready(byte_ready), .pc(pc),
      .instruction(instruction), .cpu_rst(cpu_rst), .load_done(load_done),
      .load_error(load_error), .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit got;
      got = 1'b0;
      repeat (gap) tick();
      byte_valid = 1'b1;
      byte_data  = b;
      for (int i = 0; i < 20; i++) begin
         if (byte_ready) begin
            tick();
            got = 1'b1;
            break;
         end
         tick();
      end
      byte_valid = 1'b0;
      chk("handshake", 64'(got), 64'd1);
   endtask

   task automatic chk_mem(input string tag, input int addr, input logic [15:0] exp);
      pc = 64'(addr);
      #1;
      chk(tag, 64'(instruction), 64'(exp));
   endtask

   initial begin
      rst = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; pc = '0;
      #1;
      chk("rst_cpu_rst", 64'(cpu_rst), 64'd1);
      chk("rst_byte_ready", 64'(byte_ready), 64'd0);
      chk("rst_load_done", 64'(load_done), 64'd0);
      chk("rst_load_error", 64'(load_error), 64'd0);
      chk("rst_words", 64'(words_loaded), 64'd0);
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("post_rst_cpu_rst", 64'(cpu_rst), 64'd1);

      // two-word load
      pulse_start();
      chk("start_ready", 64'(byte_ready), 64'd1);
      chk("start_words", 64'(words_loaded), 64'd0);
      send_byte(8'h02, 0); send_byte(8'h00, 0);
      send_byte(8'h34, 0); send_byte(8'h12, 0);
      send_byte(8'hCD, 0);
      chk("pre_done_cpu_rst", 64'(cpu_rst), 64'd1);
      send_byte(8'hAB, 0);
      chk("l2_done", 64'(load_done), 64'd1);
      chk("l2_cpu_rst", 64'(cpu_rst), 64'd0);
      chk("l2_words", 64'(words_loaded), 64'd2);
      chk("l2_ready", 64'(byte_ready), 64'd0);
      chk_mem("l2_mem1", 1, 16'hABCD);
      chk_mem("l2_mem0", 0, 16'h1234);
      tick();
      chk("l2_done_drop", 64'(load_done), 64'd0);
      chk("l2_cpu_rst_hold", 64'(cpu_rst), 64'd0);

      // zero-length load
      pulse_start();
      chk("zl_cpu_rst", 64'(cpu_rst), 64'd1);
      send_byte(8'h00, 0); send_byte(8'h00, 0);
      chk("zl_done", 64'(load_done), 64'd1);
      chk("zl_cpu_rst_low", 64'(cpu_rst), 64'd0);
      chk("zl_words", 64'(words_loaded), 64'd0);
      chk_mem("zl_mem0", 0, 16'h1234);
      chk_mem("zl_mem1", 1, 16'hABCD);

      // out-of-range pc reads zero
      chk_mem("pc_depth", 1024, 16'h0000);
      chk_mem("pc_alias", 1025, 16'h0000);
      pc = 64'h8000_0000_0000_0001;
      #1;
      chk("pc_huge", 64'(instruction), 64'd0);

      // length overflow N=1025
      pulse_start();
      send_byte(8'h01, 0); send_byte(8'h04, 0);
      chk("ovf_error", 64'(load_error), 64'd1);
      chk("ovf_ready", 64'(byte_ready), 64'd0);
      chk("ovf_cpu_rst", 64'(cpu_rst), 64'd1);
      byte_valid = 1'b1; byte_data = 8'h77;
      tick(); tick(); tick();
      byte_valid = 1'b0;
      chk("ovf_sticky", 64'(load_error), 64'd1);
      chk("ovf_sticky_ready", 64'(byte_ready), 64'd0);

      // N=DEPTH exactly is accepted; load_start clears the error
      pulse_start();
      chk("ovf_cleared", 64'(load_error), 64'd0);
      send_byte(8'h00, 0); send_byte(8'h04, 0);
      chk("depth_ok_error", 64'(load_error), 64'd0);
      chk("depth_ok_ready", 64'(byte_ready), 64'd1);
      chk("depth_ok_cpu_rst", 64'(cpu_rst), 64'd1);

      // three-word load with random gaps
      pulse_start();
      send_byte(8'h03, $urandom_range(0, 2)); send_byte(8'h00, $urandom_range(0, 2));
      send_byte(8'h11, $urandom_range(0, 2)); send_byte(8'h11, $urandom_range(0, 2));
      send_byte(8'h22, $urandom_range(0, 2)); send_byte(8'h22, $urandom_range(0, 2));
      send_byte(8'h33, $urandom_range(0, 2)); send_byte(8'h33, $urandom_range(0, 2));
      chk("gap_done", 64'(load_done), 64'd1);
      chk("gap_words", 64'(words_loaded), 64'd3);
      chk_mem("gap_mem0", 0, 16'h1111);
      chk_mem("gap_mem1", 1, 16'h2222);
      chk_mem("gap_mem2", 2, 16'h3333);

      // restart after the second word
      pulse_start();
      send_byte(8'h03, 0); send_byte(8'h00, 0);
      send_byte(8'hAA, 0); send_byte(8'hAA, 0);
      send_byte(8'hBB, 1); send_byte(8'hBB, 0);
      chk("rs_words2", 64'(words_loaded), 64'd2);
      pulse_start();
      chk("rs_words0", 64'(words_loaded), 64'd0);
      chk("rs_done", 64'(load_done), 64'd0);
      chk_mem("rs_mem0", 0, 16'hAAAA);
      chk_mem("rs_mem1", 1, 16'hBBBB);
      chk_mem("rs_mem2", 2, 16'h3333);

      // load_start with a simultaneous byte discards that byte
      load_start = 1'b1; byte_valid = 1'b1; byte_data = 8'h09;
      tick();
      load_start = 1'b0; byte_valid = 1'b0;
      send_byte(8'h04, 0); send_byte(8'h00, 0);
      chk("prio_ready", 64'(byte_ready), 64'd1);
      chk("prio_error", 64'(load_error), 64'd0);
      send_byte(8'h55, 0); send_byte(8'h55, 0);
      chk("mid_words1", 64'(words_loaded), 64'd1);
      send_byte(8'h66, 0);

      // reset mid-session
      rst = 1'b1;
      #1;
      chk("mid_rst_cpu_rst", 64'(cpu_rst), 64'd1);
      chk("mid_rst_ready", 64'(byte_ready), 64'd0);
      chk("mid_rst_words", 64'(words_loaded), 64'd0);
      chk("mid_rst_done", 64'(load_done), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("mid_rel_cpu_rst", 64'(cpu_rst), 64'd1);
      chk_mem("mid_mem0", 0, 16'h5555);
      chk_mem("mid_mem1", 1, 16'hBBBB);
      chk_mem("mid_pc_oob", 2048, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
